// File: rtl/modport_gpio_pkg.sv
// Shared definitions for the APB GPIO block: register indices and byte-lane write helper.
package modport_gpio_pkg;

   localparam logic [2:0] DIR     = 3'd0;
   localparam logic [2:0] OUT     = 3'd1;
   localparam logic [2:0] IN      = 3'd2;
   localparam logic [2:0] TR_TYPE = 3'd3;
   localparam logic [2:0] TR_LVL0 = 3'd4;
   localparam logic [2:0] TR_LVL1 = 3'd5;
   localparam logic [2:0] TR_STAT = 3'd6;
   localparam logic [2:0] IRQ_ENA = 3'd7;

   function automatic logic [7:0] byte_write(input logic [7:0] cur,
                                             input logic [7:0] wdata,
                                             input logic       strb);
      return strb ? wdata : cur;
   endfunction

endpackage

// File: rtl/modport_gpio_sync.sv
// Two-flop input synchroniser plus a third stage holding the previous synchronised value.
module gpio_sync #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] prev_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign prev_o = prev_q;

endmodule

// File: rtl/modport_gpio.sv
// APB3/APB4 GPIO slave: direction/output registers, synchronised inputs, level/edge IRQ with W1C status.
module modport_gpio
   import modport_gpio_pkg::*;
#(
   parameter int unsigned PADDR_SIZE = 4,
   parameter int unsigned PDATA_SIZE = 8
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic [PADDR_SIZE-1:0]   PADDR,
   input  logic                    PWRITE,
   input  logic [PDATA_SIZE/8-1:0] PSTRB,
   input  logic [PDATA_SIZE-1:0]   PWDATA,
   output logic [PDATA_SIZE-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR,
   input  logic [PDATA_SIZE-1:0]   gpio_i,
   output logic [PDATA_SIZE-1:0]   gpio_o,
   output logic [PDATA_SIZE-1:0]   gpio_oe,
   output logic                    irq_o
);

   localparam int unsigned NBYTES = PDATA_SIZE / 8;

   logic [PDATA_SIZE-1:0] dir_q,  dir_d;
   logic [PDATA_SIZE-1:0] out_q,  out_d;
   logic [PDATA_SIZE-1:0] type_q, type_d;
   logic [PDATA_SIZE-1:0] lvl0_q, lvl0_d;
   logic [PDATA_SIZE-1:0] lvl1_q, lvl1_d;
   logic [PDATA_SIZE-1:0] stat_q, stat_d;
   logic [PDATA_SIZE-1:0] ena_q,  ena_d;
   logic                  irq_q,  irq_d;

   logic [PDATA_SIZE-1:0] in_s;
   logic [PDATA_SIZE-1:0] prev_s;
   logic [PDATA_SIZE-1:0] trig;
   logic [PDATA_SIZE-1:0] clr;
   logic [PDATA_SIZE-1:0] rdata;
   logic [2:0]            idx;
   logic                  addr_ok;
   logic                  access;
   logic                  err;
   logic                  wr_en;

   function automatic logic [PDATA_SIZE-1:0] merge(input logic [PDATA_SIZE-1:0] cur,
                                                   input logic [PDATA_SIZE-1:0] wdata,
                                                   input logic [NBYTES-1:0]     strb);
      logic [PDATA_SIZE-1:0] res;
      for (int b = 0; b < NBYTES; b++) begin
         res[b*8 +: 8] = byte_write(cur[b*8 +: 8], wdata[b*8 +: 8], strb[b]);
      end
      return res;
   endfunction

   gpio_sync #(
      .WIDTH(PDATA_SIZE)
   ) u_sync (
      .clk_i (PCLK),
      .rst_ni(PRESETn),
      .d_i   (gpio_i),
      .sync_o(in_s),
      .prev_o(prev_s)
   );

   assign idx     = PADDR[2:0];
   assign addr_ok = (PADDR[PADDR_SIZE-1:3] == '0);
   assign access  = PSEL & PENABLE;
   // Out-of-range addresses and writes to the read-only input register error out and commit nothing.
   assign err     = access & (~addr_ok | (PWRITE & (idx == IN)));
   assign wr_en   = access & PWRITE & ~err;

   assign trig = (~type_q & ((lvl1_q & in_s) | (lvl0_q & ~in_s)))
               | ( type_q & ((lvl1_q & in_s & ~prev_s) | (lvl0_q & ~in_s & prev_s)));

   always_comb begin
      dir_d  = dir_q;
      out_d  = out_q;
      type_d = type_q;
      lvl0_d = lvl0_q;
      lvl1_d = lvl1_q;
      ena_d  = ena_q;
      clr    = '0;
      if (wr_en) begin
         case (idx)
            DIR:     dir_d  = merge(dir_q,  PWDATA, PSTRB);
            OUT:     out_d  = merge(out_q,  PWDATA, PSTRB);
            TR_TYPE: type_d = merge(type_q, PWDATA, PSTRB);
            TR_LVL0: lvl0_d = merge(lvl0_q, PWDATA, PSTRB);
            TR_LVL1: lvl1_d = merge(lvl1_q, PWDATA, PSTRB);
            TR_STAT: clr    = merge('0,     PWDATA, PSTRB);
            IRQ_ENA: ena_d  = merge(ena_q,  PWDATA, PSTRB);
            default: ;
         endcase
      end
      // A new trigger wins over a same-cycle W1C clear.
      stat_d = (stat_q & ~clr) | trig;
      irq_d  = |(stat_q & ena_q);
   end

   always_comb begin
      rdata = '0;
      if (PSEL && !PWRITE && addr_ok) begin
         case (idx)
            DIR:     rdata = dir_q;
            OUT:     rdata = out_q;
            IN:      rdata = in_s;
            TR_TYPE: rdata = type_q;
            TR_LVL0: rdata = lvl0_q;
            TR_LVL1: rdata = lvl1_q;
            TR_STAT: rdata = stat_q;
            IRQ_ENA: rdata = ena_q;
            default: rdata = '0;
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         dir_q  <= '0;
         out_q  <= '0;
         type_q <= '0;
         lvl0_q <= '0;
         lvl1_q <= '0;
         stat_q <= '0;
         ena_q  <= '0;
         irq_q  <= 1'b0;
      end else begin
         dir_q  <= dir_d;
         out_q  <= out_d;
         type_q <= type_d;
         lvl0_q <= lvl0_d;
         lvl1_q <= lvl1_d;
         stat_q <= stat_d;
         ena_q  <= ena_d;
         irq_q  <= irq_d;
      end
   end

   assign PRDATA  = rdata;
   assign PREADY  = 1'b1;
   assign PSLVERR = err;
   assign gpio_o  = out_q;
   assign gpio_oe = dir_q;
   assign irq_o   = irq_q;

endmodule

// File: tb/tb_modport_gpio.sv
// Bench for modport_gpio (32-bit instance): vector table, directed IRQ/reset sequences, random traffic vs model.
module tb_modport_gpio;

   localparam int AW = 4;
   localparam int DW = 32;

   logic            PCLK = 1'b0;
   logic            PRESETn = 1'b0;
   logic            PSEL = 1'b0;
   logic            PENABLE = 1'b0;
   logic            PWRITE = 1'b0;
   logic [AW-1:0]   PADDR = '0;
   logic [DW/8-1:0] PSTRB = '0;
   logic [DW-1:0]   PWDATA = '0;
   logic [DW-1:0]   PRDATA;
   logic            PREADY;
   logic            PSLVERR;
   logic [DW-1:0]   gpio_i = '0;
   logic [DW-1:0]   gpio_o;
   logic [DW-1:0]   gpio_oe;
   logic            irq_o;

   int n_chk  = 0;
   int n_fail = 0;
   bit mon_on = 1'b0;

   always #5 PCLK = ~PCLK;

   modport_gpio #(
      .PADDR_SIZE(AW),
      .PDATA_SIZE(DW)
   ) dut (
      .PCLK   (PCLK),
      .PRESETn(PRESETn),
      .PSEL   (PSEL),
      .PENABLE(PENABLE),
      .PADDR  (PADDR),
      .PWRITE (PWRITE),
      .PSTRB  (PSTRB),
      .PWDATA (PWDATA),
      .PRDATA (PRDATA),
      .PREADY (PREADY),
      .PSLVERR(PSLVERR),
      .gpio_i (gpio_i),
      .gpio_o (gpio_o),
      .gpio_oe(gpio_oe),
      .irq_o  (irq_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: register file array, pin history (index 1 = visible IN, index 2 = previous IN)
   logic [DW-1:0] m_reg  [8];
   logic [DW-1:0] m_hist [3];
   logic          m_irq;

   function automatic bit m_wr_hits(input int r);
      return PSEL && PENABLE && PWRITE && !PADDR[3] && (PADDR[2:0] != 3'd2) && (int'(PADDR[2:0]) == r);
   endfunction

   function automatic logic [DW-1:0] m_wr(input int r);
      logic [DW-1:0] v;
      v = m_reg[r];
      if (m_wr_hits(r))
         for (int b = 0; b < DW/8; b++)
            if (PSTRB[b]) v[b*8 +: 8] = PWDATA[b*8 +: 8];
      return v;
   endfunction

   function automatic logic [DW-1:0] m_clr();
      logic [DW-1:0] v;
      v = '0;
      if (m_wr_hits(6))
         for (int b = 0; b < DW/8; b++)
            if (PSTRB[b]) v[b*8 +: 8] = PWDATA[b*8 +: 8];
      return v;
   endfunction

   function automatic logic [DW-1:0] m_trig();
      logic [DW-1:0] t;
      for (int i = 0; i < DW; i++) begin
         if (m_reg[3][i])
            t[i] = (m_reg[5][i] && m_hist[1][i] && !m_hist[2][i]) ||
                   (m_reg[4][i] && !m_hist[1][i] && m_hist[2][i]);
         else
            t[i] = (m_reg[5][i] && m_hist[1][i]) || (m_reg[4][i] && !m_hist[1][i]);
      end
      return t;
   endfunction

   function automatic logic [DW-1:0] m_read(input logic [3:0] a);
      if (a[3]) return '0;
      if (a[2:0] == 3'd2) return m_hist[1];
      return m_reg[a[2:0]];
   endfunction

   function automatic logic m_err(input logic [3:0] a, input logic wr);
      return a[3] || (wr && (a[2:0] == 3'd2));
   endfunction

   always @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int r = 0; r < 8; r++) m_reg[r] <= '0;
         for (int k = 0; k < 3; k++) m_hist[k] <= '0;
         m_irq <= 1'b0;
      end else begin
         for (int r = 0; r < 8; r++)
            if (r != 6) m_reg[r] <= m_wr(r);
         m_reg[6]  <= (m_reg[6] & ~m_clr()) | m_trig();
         m_irq     <= |(m_reg[6] & m_reg[7]);
         m_hist[0] <= gpio_i;
         m_hist[1] <= m_hist[0];
         m_hist[2] <= m_hist[1];
      end
   end

   always @(negedge PCLK) begin
      if (mon_on) begin
         check("mon_gpio_o",  gpio_o,  m_reg[1]);
         check("mon_gpio_oe", gpio_oe, m_reg[0]);
         check("mon_irq_o",   {31'b0, irq_o}, {31'b0, m_irq});
         check("mon_pready",  {31'b0, PREADY}, 32'd1);
      end
   end

   task automatic apb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic err, output logic exp_err);
      @(negedge PCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d; PSTRB = s;
      @(negedge PCLK);
      PENABLE = 1'b1;
      #1;
      err     = PSLVERR;
      exp_err = m_err(a, 1'b1);
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic err,
                           output logic [31:0] exp_d, output logic exp_err);
      @(negedge PCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
      @(negedge PCLK);
      PENABLE = 1'b1;
      #1;
      d       = PRDATA;
      err     = PSLVERR;
      exp_d   = m_read(a);
      exp_err = m_err(a, 1'b0);
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wait_irq(input logic exp, input int maxc, input string name);
      int c;
      c = 0;
      while (irq_o !== exp && c < maxc) begin
         @(posedge PCLK);
         #1;
         c++;
      end
      check(name, {31'b0, irq_o}, {31'b0, exp});
   endtask

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   localparam int NV = 15;
   vec_t tbl [NV];

   initial begin
      logic [31:0] rd, md, d;
      logic        e, me;
      logic [3:0]  a, s;

      tbl[0]  = '{wr:1'b0, addr:4'd0, wdata:32'h0,        strb:4'h0, exp_rd:32'h0,        exp_err:1'b0};
      tbl[1]  = '{wr:1'b0, addr:4'd7, wdata:32'h0,        strb:4'h0, exp_rd:32'h0,        exp_err:1'b0};
      tbl[2]  = '{wr:1'b1, addr:4'd1, wdata:32'hFFFFFFFF, strb:4'b0010, exp_rd:32'h0,     exp_err:1'b0};
      tbl[3]  = '{wr:1'b0, addr:4'd1, wdata:32'h0,        strb:4'h0, exp_rd:32'h0000FF00, exp_err:1'b0};
      tbl[4]  = '{wr:1'b1, addr:4'd0, wdata:32'h000000FF, strb:4'hF, exp_rd:32'h0,        exp_err:1'b0};
      tbl[5]  = '{wr:1'b1, addr:4'd1, wdata:32'h000000A5, strb:4'hF, exp_rd:32'h0,        exp_err:1'b0};
      tbl[6]  = '{wr:1'b0, addr:4'd0, wdata:32'h0,        strb:4'h0, exp_rd:32'h000000FF, exp_err:1'b0};
      tbl[7]  = '{wr:1'b0, addr:4'd1, wdata:32'h0,        strb:4'h0, exp_rd:32'h000000A5, exp_err:1'b0};
      tbl[8]  = '{wr:1'b1, addr:4'd2, wdata:32'hFFFFFFFF, strb:4'hF, exp_rd:32'h0,        exp_err:1'b1};
      tbl[9]  = '{wr:1'b0, addr:4'd2, wdata:32'h0,        strb:4'h0, exp_rd:32'h0,        exp_err:1'b0};
      tbl[10] = '{wr:1'b1, addr:4'd8, wdata:32'h12345678, strb:4'hF, exp_rd:32'h0,        exp_err:1'b1};
      tbl[11] = '{wr:1'b0, addr:4'd8, wdata:32'h0,        strb:4'h0, exp_rd:32'h0,        exp_err:1'b1};
      tbl[12] = '{wr:1'b0, addr:4'd0, wdata:32'h0,        strb:4'h0, exp_rd:32'h000000FF, exp_err:1'b0};
      tbl[13] = '{wr:1'b1, addr:4'd9, wdata:32'h0,        strb:4'hF, exp_rd:32'h0,        exp_err:1'b1};
      tbl[14] = '{wr:1'b0, addr:4'd1, wdata:32'h0,        strb:4'h0, exp_rd:32'h000000A5, exp_err:1'b0};

      // Reset state
      repeat (3) @(negedge PCLK);
      #1;
      check("rst_gpio_o",  gpio_o,  32'h0);
      check("rst_gpio_oe", gpio_oe, 32'h0);
      check("rst_irq",     {31'b0, irq_o},   32'h0);
      check("rst_prdata",  PRDATA,  32'h0);
      check("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      mon_on  = 1'b1;

      for (int i = 0; i < NV; i++) begin
         if (tbl[i].wr) begin
            apb_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb, e, me);
            check($sformatf("tbl%0d_err", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
         end else begin
            apb_read(tbl[i].addr, rd, e, md, me);
            check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_err", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
         end
      end
      check("dir_oe",  gpio_oe, 32'h000000FF);
      check("out_val", gpio_o,  32'h000000A5);

      // Synchroniser latency
      @(negedge PCLK);
      gpio_i = 32'h3C; PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 4'd2;
      @(posedge PCLK); #1;
      check("in_after_1", PRDATA, 32'h0);
      @(posedge PCLK); @(posedge PCLK); #1;
      check("in_after_3", PRDATA, 32'h3C);
      @(negedge PCLK);
      PSEL = 1'b0;

      // Rising-edge trigger on bit 0
      apb_write(4'd3, 32'h01, 4'hF, e, me);
      apb_write(4'd5, 32'h01, 4'hF, e, me);
      apb_write(4'd7, 32'h01, 4'hF, e, me);
      check("edge_idle_irq", {31'b0, irq_o}, 32'h0);
      @(negedge PCLK);
      gpio_i = 32'h3D;
      wait_irq(1'b1, 8, "edge_irq_set");
      apb_read(4'd6, rd, e, md, me);
      check("edge_stat", rd, 32'h01);
      apb_write(4'd6, 32'h01, 4'hF, e, me);
      wait_irq(1'b0, 4, "edge_irq_clr");
      repeat (5) @(negedge PCLK);
      #1;
      check("edge_irq_stays0", {31'b0, irq_o}, 32'h0);
      apb_read(4'd6, rd, e, md, me);
      check("edge_stat_clr", rd, 32'h0);

      // Low-level trigger on bit 3
      apb_write(4'd5, 32'h00, 4'hF, e, me);
      apb_write(4'd3, 32'h00, 4'hF, e, me);
      @(negedge PCLK);
      gpio_i = 32'h35;
      apb_write(4'd4, 32'h08, 4'hF, e, me);
      apb_write(4'd7, 32'h08, 4'hF, e, me);
      wait_irq(1'b1, 8, "lvl_irq_set");
      apb_write(4'd6, 32'h08, 4'hF, e, me);
      repeat (2) @(negedge PCLK);
      #1;
      check("lvl_irq_held", {31'b0, irq_o}, 32'h1);
      apb_read(4'd6, rd, e, md, me);
      check("lvl_stat_reset", rd, 32'h08);
      @(negedge PCLK);
      gpio_i = 32'h3D;
      repeat (4) @(negedge PCLK);
      apb_write(4'd6, 32'h08, 4'hF, e, me);
      wait_irq(1'b0, 4, "lvl_irq_clr");
      apb_read(4'd6, rd, e, md, me);
      check("lvl_stat_clr", rd, 32'h0);

      // Asynchronous reset in the middle of a write
      @(negedge PCLK);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 4'd0; PWDATA = 32'h0F; PSTRB = 4'hF;
      @(negedge PCLK);
      PENABLE = 1'b1;
      #2;
      PRESETn = 1'b0;
      #1;
      check("arst_gpio_oe", gpio_oe, 32'h0);
      check("arst_gpio_o",  gpio_o,  32'h0);
      check("arst_irq",     {31'b0, irq_o}, 32'h0);
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      @(negedge PCLK);
      PRESETn = 1'b1;
      apb_read(4'd0, rd, e, md, me);
      check("arst_dir", rd, 32'h0);
      apb_read(4'd1, rd, e, md, me);
      check("arst_out", rd, 32'h0);

      // Randomised traffic against the model
      for (int it = 0; it < 300; it++) begin
         case ($urandom_range(0, 2))
            0: begin
               @(negedge PCLK);
               gpio_i = $urandom;
            end
            1: begin
               a = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
               d = $urandom;
               s = 4'($urandom);
               apb_write(a, d, s, e, me);
               check("rnd_wr_err", {31'b0, e}, {31'b0, me});
            end
            default: begin
               a = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
               apb_read(a, rd, e, md, me);
               check("rnd_rd", rd, md);
               check("rnd_rd_err", {31'b0, e}, {31'b0, me});
            end
         endcase
      end

      mon_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
